// File: rtl/beat_scorer_if.sv
// Signal bundle between the beat stage / song ROM / key inputs and the beat scorer.
// The scorer uses the slave view; whatever drives the beats and keys uses master.
interface beat_scorer_if #(
  parameter int BEAT_BITS   = 8,
  parameter int NOTE_BITS   = 4,
  parameter int SCORE_BITS  = 16,
  parameter int STREAK_BITS = 8
);
  logic                   playing;
  logic [BEAT_BITS-1:0]   cur_beat;
  logic                   new_beat;
  logic [BEAT_BITS-1:0]   song_addr;
  logic [NOTE_BITS-1:0]   song_data;
  logic [NOTE_BITS-1:0]   keys;
  logic                   hit;
  logic                   miss;
  logic [SCORE_BITS-1:0]  score;
  logic [STREAK_BITS-1:0] streak;
  logic                   done;

  modport master (
    output playing, cur_beat, new_beat, song_data, keys,
    input  song_addr, hit, miss, score, streak, done
  );

  modport slave (
    input  playing, cur_beat, new_beat, song_data, keys,
    output song_addr, hit, miss, score, streak, done
  );
endinterface

// File: rtl/beat_scorer.sv
// Judges key-press edges against the charted note of each beat and keeps a saturating
// score and hit streak; each beat is judged at most once.
module beat_scorer #(
  parameter int BEAT_BITS   = 8,
  parameter int NOTE_BITS   = 4,
  parameter int SCORE_BITS  = 16,
  parameter int STREAK_BITS = 8,
  parameter int POINTS      = 10,
  parameter int SONG_BEATS  = 64
) (
  input logic           clk,
  input logic           rst,
  beat_scorer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACTIVE,
    JUDGED,
    DONE
  } state_t;

  localparam logic [BEAT_BITS-1:0] END_BEAT = BEAT_BITS'(SONG_BEATS);

  state_t                 state_q, state_d;
  logic [NOTE_BITS-1:0]   prev_keys_q;
  logic [NOTE_BITS-1:0]   press_mask_q, press_mask_d;
  logic [NOTE_BITS-1:0]   expected_q, expected_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic                   done_q, done_d;
  logic [SCORE_BITS-1:0]  score_q, score_d;
  logic [STREAK_BITS-1:0] streak_q, streak_d;

  logic [NOTE_BITS-1:0]   edges;
  logic [SCORE_BITS:0]    score_sum;
  logic [SCORE_BITS-1:0]  score_sat;
  logic [STREAK_BITS-1:0] streak_sat;
  logic                   is_note, bad_press, full_press, song_over, at_end;

  assign bus.song_addr = bus.cur_beat;

  assign edges      = bus.keys & ~prev_keys_q;
  assign is_note    = |expected_q;
  assign bad_press  = |(press_mask_q & ~expected_q);
  assign full_press = (press_mask_q == expected_q);
  assign song_over  = (bus.cur_beat >= END_BEAT);
  assign at_end     = (bus.cur_beat == END_BEAT);

  assign score_sum  = {1'b0, score_q} + (SCORE_BITS+1)'(POINTS);
  assign score_sat  = score_sum[SCORE_BITS] ? {SCORE_BITS{1'b1}} : score_sum[SCORE_BITS-1:0];
  assign streak_sat = (&streak_q) ? streak_q : streak_q + STREAK_BITS'(1);

  always_comb begin
    state_d      = state_q;
    press_mask_d = press_mask_q | edges;
    expected_d   = expected_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.playing) state_d = song_over ? DONE : FETCH;
      end
      FETCH: begin
        expected_d = bus.song_data;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        // A new beat overrides any press completing in the same cycle.
        if (bus.new_beat) begin
          miss_d  = is_note;
          state_d = at_end ? DONE : FETCH;
        end else if (is_note && bad_press) begin
          miss_d  = 1'b1;
          state_d = JUDGED;
        end else if (is_note && full_press) begin
          hit_d   = 1'b1;
          state_d = JUDGED;
        end
      end
      JUDGED: begin
        if (bus.new_beat) state_d = at_end ? DONE : FETCH;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != DONE && !bus.playing) begin
      state_d = IDLE;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
    end

    // Edges arriving in the same cycle as the new beat belong to that beat.
    if (state_d == FETCH) press_mask_d = edges;
  end

  always_comb begin
    score_d  = score_q;
    streak_d = streak_q;
    if (hit_d) begin
      score_d  = score_sat;
      streak_d = streak_sat;
    end else if (miss_d) begin
      streak_d = '0;
    end
  end

  assign done_d = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_keys_q  <= '0;
      press_mask_q <= '0;
      expected_q   <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      done_q       <= 1'b0;
      score_q      <= '0;
      streak_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_keys_q  <= bus.keys;
      press_mask_q <= press_mask_d;
      expected_q   <= expected_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      done_q       <= done_d;
      score_q      <= score_d;
      streak_q     <= streak_d;
    end
  end

  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
  assign bus.done   = done_q;
  assign bus.score  = score_q;
  assign bus.streak = streak_q;

endmodule

// File: tb/tb_beat_scorer.sv
// Bench for beat_scorer: a fixed vector table, hand-driven corner sequences, then random
// play compared cycle by cycle against a rule-level model of beat judging.
module tb_beat_scorer;

  localparam int BEAT_BITS   = 8;
  localparam int NOTE_BITS   = 4;
  localparam int SCORE_BITS  = 16;
  localparam int STREAK_BITS = 8;
  localparam int POINTS      = 10;
  localparam int SONG_BEATS  = 64;
  localparam int SCORE_MAX   = (1 << SCORE_BITS) - 1;
  localparam int STREAK_MAX  = (1 << STREAK_BITS) - 1;

  typedef struct {
    logic       r;
    logic       p;
    logic [7:0] b;
    logic       nb;
    logic [3:0] k;
    logic       h;
    logic       m;
    int         s;
    int         st;
  } vec_t;

  logic clk;
  logic rst;
  logic [3:0] chart [256];
  vec_t vecs[$];
  int tests;
  int failures;

  // Reference model state: where we are inside the current beat, not an FSM copy.
  logic [3:0] mPrev, mMask, mExp;
  logic [7:0] mLastBeat;
  int mScore, mStreak, mPhase;
  bit mHit, mMiss, mDone, mActive;

  beat_scorer_if #(
    .BEAT_BITS(BEAT_BITS), .NOTE_BITS(NOTE_BITS),
    .SCORE_BITS(SCORE_BITS), .STREAK_BITS(STREAK_BITS)
  ) bus ();

  beat_scorer #(
    .BEAT_BITS(BEAT_BITS), .NOTE_BITS(NOTE_BITS), .SCORE_BITS(SCORE_BITS),
    .STREAK_BITS(STREAK_BITS), .POINTS(POINTS), .SONG_BEATS(SONG_BEATS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.song_data <= chart[bus.song_addr];

  task automatic modelStep();
    logic [3:0] k;
    logic [3:0] e;
    bit judgeable;
    k = bus.keys;
    e = k & ~mPrev;
    mHit = 0;
    mMiss = 0;
    if (rst) begin
      mPrev = '0; mMask = '0; mExp = '0;
      mScore = 0; mStreak = 0; mPhase = 0;
      mDone = 0; mActive = 0;
    end else begin
      mPrev = k;
      if (mDone) begin
        mDone = 1;
      end else if (!bus.playing) begin
        mActive = 0;
      end else if (!mActive) begin
        if (int'(bus.cur_beat) >= SONG_BEATS) mDone = 1;
        else begin mActive = 1; mPhase = 0; mMask = e; end
      end else if (mPhase == 0) begin
        mExp = chart[mLastBeat];
        mPhase = 1;
        mMask = mMask | e;
      end else begin
        judgeable = (mPhase == 1) && (mExp != 0);
        if (bus.new_beat) begin
          mMiss = judgeable;
          if (int'(bus.cur_beat) == SONG_BEATS) mDone = 1;
          else begin mPhase = 0; mMask = e; end
        end else begin
          if (judgeable && (mMask & ~mExp) != 0) begin mMiss = 1; mPhase = 2; end
          else if (judgeable && mMask == mExp) begin mHit = 1; mPhase = 2; end
          mMask = mMask | e;
        end
      end
      if (mHit) begin
        mScore  = (mScore + POINTS > SCORE_MAX) ? SCORE_MAX : mScore + POINTS;
        mStreak = (mStreak == STREAK_MAX) ? STREAK_MAX : mStreak + 1;
      end
      if (mMiss) mStreak = 0;
    end
    mLastBeat = bus.cur_beat;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic [7:0] b,
                               input logic nb, input logic [3:0] k);
    rst          = r;
    bus.playing  = p;
    bus.cur_beat = b;
    bus.new_beat = nb;
    bus.keys     = k;
    tick();
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkModel(input int cyc);
    tests++;
    if (bus.hit !== mHit || bus.miss !== mMiss || bus.done !== mDone ||
        int'(bus.score) != mScore || int'(bus.streak) != mStreak ||
        bus.song_addr !== bus.cur_beat) begin
      failures++;
      $display("[TB] FAIL random cycle %0d: got hit=%b miss=%b score=%0d streak=%0d done=%b addr=%0d expected hit=%b miss=%b score=%0d streak=%0d done=%b addr=%0d",
               cyc, bus.hit, bus.miss, bus.score, bus.streak, bus.done, bus.song_addr,
               mHit, mMiss, mScore, mStreak, mDone, bus.cur_beat);
    end
  endtask

  // Four-cycle beat: new_beat with the press edge, release, judge, settle.
  task automatic beatCycle(input logic [7:0] b, input logic [3:0] press, input bit chk,
                           input bit expMiss0, input bit expHit, input bit expMiss,
                           input int expScore, input int expStreak);
    applyStimulus(1'b0, 1'b1, b, 1'b1, press);
    if (chk) checkOutput($sformatf("beat%0d.missAtNewBeat", b), int'(bus.miss), int'(expMiss0));
    applyStimulus(1'b0, 1'b1, b, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, b, 1'b0, 4'b0000);
    if (chk) begin
      checkOutput($sformatf("beat%0d.hit", b), int'(bus.hit), int'(expHit));
      checkOutput($sformatf("beat%0d.miss", b), int'(bus.miss), int'(expMiss));
      checkOutput($sformatf("beat%0d.score", b), int'(bus.score), expScore);
      checkOutput($sformatf("beat%0d.streak", b), int'(bus.streak), expStreak);
    end
    applyStimulus(1'b0, 1'b1, b, 1'b0, 4'b0000);
  endtask

  task automatic addVec(input logic r, input logic p, input logic [7:0] b, input logic nb,
                        input logic [3:0] k, input logic h, input logic m, input int s,
                        input int st);
    vec_t v;
    v.r = r; v.p = p; v.b = b; v.nb = nb; v.k = k;
    v.h = h; v.m = m; v.s = s; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    int gap;
    int doneRun;
    logic [7:0] beat;
    logic [3:0] keysNow;
    logic rstIn;
    logic nbIn;

    tests = 0;
    failures = 0;
    foreach (chart[i]) chart[i] = 4'b0000;
    chart[0]  = 4'b0010; chart[1]  = 4'b0011; chart[2]  = 4'b0011; chart[3] = 4'b0100;
    chart[4]  = 4'b0000; chart[5]  = 4'b0001; chart[6]  = 4'b0001; chart[7] = 4'b0010;
    chart[8]  = 4'b0100; chart[9]  = 4'b1000; chart[10] = 4'b0000; chart[11] = 4'b0001;
    chart[12] = 4'b0001; chart[13] = 4'b0010;

    //     r  p  beat nb keys     h  m  score streak
    addVec(0, 1, 0, 1, 4'b0000, 0, 0, 0,  0);
    addVec(0, 1, 0, 0, 4'b0000, 0, 0, 0,  0);
    addVec(0, 1, 0, 0, 4'b0010, 0, 0, 0,  0);
    addVec(0, 1, 0, 0, 4'b0010, 1, 0, 10, 1);
    addVec(0, 1, 0, 0, 4'b0010, 0, 0, 10, 1);
    addVec(0, 1, 1, 1, 4'b0000, 0, 0, 10, 1);
    addVec(0, 1, 1, 0, 4'b0001, 0, 0, 10, 1);
    addVec(0, 1, 1, 0, 4'b0001, 0, 0, 10, 1);
    addVec(0, 1, 1, 0, 4'b0011, 0, 0, 10, 1);
    addVec(0, 1, 1, 0, 4'b0011, 1, 0, 20, 2);
    addVec(0, 1, 1, 0, 4'b0000, 0, 0, 20, 2);
    addVec(0, 1, 2, 1, 4'b0100, 0, 0, 20, 2);
    addVec(0, 1, 2, 0, 4'b0100, 0, 0, 20, 2);
    addVec(0, 1, 2, 0, 4'b0111, 0, 1, 20, 0);
    addVec(0, 1, 2, 0, 4'b0111, 0, 0, 20, 0);
    addVec(0, 1, 2, 0, 4'b0000, 0, 0, 20, 0);
    addVec(0, 1, 3, 1, 4'b0000, 0, 0, 20, 0);
    addVec(0, 1, 3, 0, 4'b0000, 0, 0, 20, 0);
    addVec(0, 1, 3, 0, 4'b0000, 0, 0, 20, 0);
    addVec(0, 1, 4, 1, 4'b0000, 0, 1, 20, 0);
    addVec(0, 1, 4, 0, 4'b1111, 0, 0, 20, 0);
    addVec(0, 1, 4, 0, 4'b0000, 0, 0, 20, 0);
    addVec(0, 1, 4, 0, 4'b0001, 0, 0, 20, 0);
    addVec(0, 1, 5, 1, 4'b0001, 0, 0, 20, 0);
    addVec(0, 1, 5, 0, 4'b0001, 0, 0, 20, 0);
    addVec(0, 1, 5, 0, 4'b0001, 0, 0, 20, 0);
    addVec(0, 1, 5, 0, 4'b0001, 0, 0, 20, 0);
    addVec(0, 1, 6, 1, 4'b0001, 0, 1, 20, 0);
    addVec(0, 1, 6, 0, 4'b0000, 0, 0, 20, 0);
    addVec(0, 1, 6, 0, 4'b0001, 0, 0, 20, 0);
    addVec(1, 1, 6, 0, 4'b0001, 0, 0, 0,  0);
    addVec(0, 0, 6, 0, 4'b0000, 0, 0, 0,  0);

    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 4'b0000);
    checkOutput("reset.hit", int'(bus.hit), 0);
    checkOutput("reset.miss", int'(bus.miss), 0);
    checkOutput("reset.score", int'(bus.score), 0);
    checkOutput("reset.streak", int'(bus.streak), 0);
    checkOutput("reset.done", int'(bus.done), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].p, vecs[i].b, vecs[i].nb, vecs[i].k);
      checkOutput($sformatf("vec%0d.hit", i), int'(bus.hit), int'(vecs[i].h));
      checkOutput($sformatf("vec%0d.miss", i), int'(bus.miss), int'(vecs[i].m));
      checkOutput($sformatf("vec%0d.score", i), int'(bus.score), vecs[i].s);
      checkOutput($sformatf("vec%0d.streak", i), int'(bus.streak), vecs[i].st);
      checkOutput($sformatf("vec%0d.addr", i), int'(bus.song_addr), int'(vecs[i].b));
    end

    // Streak builds to 3, a rest beat passes, then an unpressed note beat breaks it.
    beatCycle(8'd6,  4'b0001, 1, 0, 1, 0, 10, 1);
    beatCycle(8'd7,  4'b0010, 1, 0, 1, 0, 20, 2);
    beatCycle(8'd8,  4'b0100, 1, 0, 1, 0, 30, 3);
    beatCycle(8'd9,  4'b0000, 1, 0, 0, 0, 30, 3);
    beatCycle(8'd10, 4'b0000, 1, 1, 0, 0, 30, 0);

    // Pause while a note is still unjudged, then resume.
    applyStimulus(1'b0, 1'b1, 8'd11, 1'b1, 4'b0000);
    checkOutput("restNewBeat.miss", int'(bus.miss), 0);
    applyStimulus(1'b0, 1'b1, 8'd11, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 8'd11, 1'b0, 4'b0000);
    checkOutput("pause.miss", int'(bus.miss), 0);
    applyStimulus(1'b0, 1'b0, 8'd11, 1'b1, 4'b0000);
    checkOutput("pauseNewBeat.miss", int'(bus.miss), 0);
    checkOutput("pause.score", int'(bus.score), 30);
    beatCycle(8'd11, 4'b0001, 1, 0, 1, 0, 40, 1);

    // End of song from JUDGED; done holds through pause and new beats.
    applyStimulus(1'b0, 1'b1, 8'd64, 1'b1, 4'b0000);
    checkOutput("songEnd.done", int'(bus.done), 1);
    checkOutput("songEnd.miss", int'(bus.miss), 0);
    applyStimulus(1'b0, 1'b0, 8'd65, 1'b1, 4'b1111);
    applyStimulus(1'b0, 1'b1, 8'd65, 1'b0, 4'b0000);
    checkOutput("doneHold.done", int'(bus.done), 1);
    checkOutput("doneHold.score", int'(bus.score), 40);

    // Starting play with the beat already past the song goes straight to done.
    applyStimulus(1'b1, 1'b0, 8'd70, 1'b0, 4'b0000);
    checkOutput("resetFromDone.done", int'(bus.done), 0);
    applyStimulus(1'b0, 1'b1, 8'd70, 1'b0, 4'b0000);
    checkOutput("idlePastEnd.done", int'(bus.done), 1);

    // Long hit run to saturate streak and score.
    applyStimulus(1'b1, 1'b0, 8'd12, 1'b0, 4'b0000);
    for (int i = 1; i <= 6555; i++) begin
      beat = (i % 2 == 0) ? 8'd12 : 8'd13;
      beatCycle(beat, chart[beat], 0, 0, 0, 0, 0, 0);
      if (i == 255)  checkOutput("streakAt255", int'(bus.streak), 255);
      if (i == 256)  checkOutput("streakSaturated", int'(bus.streak), 255);
      if (i == 6553) checkOutput("scoreBeforeMax", int'(bus.score), 65530);
      if (i == 6554) checkOutput("scoreSaturated", int'(bus.score), 65535);
      if (i == 6555) checkOutput("scoreHeldAtMax", int'(bus.score), 65535);
    end

    // Random play against the model.
    for (int i = 40; i <= 75; i++) chart[i] = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    applyStimulus(1'b1, 1'b0, 8'd50, 1'b0, 4'b0000);
    gap = 3;
    doneRun = 0;
    beat = 8'd50;
    keysNow = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      rstIn = 1'b0;
      nbIn = 1'b0;
      if (mDone) doneRun++;
      else doneRun = 0;
      if (doneRun > 6) begin
        rstIn = 1'b1;
        beat = 8'(40 + $urandom_range(0, 20));
        doneRun = 0;
      end else if ($urandom_range(0, 499) == 0) begin
        rstIn = 1'b1;
      end
      if (gap == 0) begin
        nbIn = 1'b1;
        beat = beat + 8'd1;
        if (beat > 8'd70) beat = 8'd45;
        gap = $urandom_range(3, 9);
      end else begin
        gap--;
      end
      keysNow = keysNow ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      applyStimulus(rstIn, ($urandom_range(0, 19) != 0), beat, nbIn, keysNow);
      checkModel(i);
      checkOutput("hitMissExclusive", int'(bus.hit & bus.miss), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/beat_scorer.md
# beat_scorer

Judges player key presses against the song chart, one beat at a time, and keeps score. It sits directly downstream of the beat stage: it consumes `cur_beat` and the `new_beat` pulse, fetches the expected note for each beat from the synchronous song ROM, and compares it with key-press edges. It drives hit/miss pulses, score, streak and song-done status to the display logic.

## Interface
- `BEAT_BITS`, 8: width of the beat index and ROM address.
- `NOTE_BITS`, 4: number of keys; also the width of a chart entry (bitmask, 0 = rest).
- `SCORE_BITS`, 16: score width.
- `STREAK_BITS`, 8: streak width.
- `POINTS`, 10: points added per hit.
- `SONG_BEATS`, 64: beat index at which the song ends.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `playing` in 1: song running; low = paused or stopped.
- `cur_beat` in BEAT_BITS: current beat index from the beat stage.
- `new_beat` in 1: one-cycle pulse, high in the first cycle of each new `cur_beat`.
- `song_addr` out BEAT_BITS: ROM address, combinationally equal to `cur_beat`.
- `song_data` in NOTE_BITS: ROM data, valid 1 cycle after the address.
- `keys` in NOTE_BITS: debounced key levels, 1 = held.
- `hit` out 1: one-cycle pulse, beat judged correct.
- `miss` out 1: one-cycle pulse, beat judged wrong or missed.
- `score` out SCORE_BITS: accumulated score.
- `streak` out STREAK_BITS: consecutive hits.
- `done` out 1: song finished; level output.

## Operation
- Key edges: `prev_keys` is registered. `edges = keys & ~prev_keys`. `prev_keys` updates every cycle, including in IDLE.
- `press_mask`: ORs in `edges`. It is cleared on entry to FETCH, and edges seen in that entry cycle are kept.
- `expected`: latched from `song_data` in FETCH.
- FSM states:
  - IDLE:
    - `playing`=1 → FETCH.
    - If `cur_beat` ≥ SONG_BEATS, go → DONE instead.
  - FETCH: one cycle. Latch `expected` → ACTIVE.
  - ACTIVE, evaluated each cycle, first match wins:
    1. `new_beat`: if `expected`≠0, emit miss (unjudged beat). Then → FETCH, or → DONE if `cur_beat` == SONG_BEATS.
    2. `expected`≠0 and `press_mask` has a bit outside `expected`: emit miss → JUDGED.
    3. `expected`≠0 and `press_mask` == `expected`: emit hit → JUDGED.
    - Presses during a rest (`expected`=0) are ignored.
  - JUDGED: wait for `new_beat`, then → FETCH or DONE as in ACTIVE. No further judging this beat.
  - DONE: `done`=1; hold until `rst`.
  - Any state except DONE: `playing`=0 → IDLE. No miss is emitted; score and streak are held.
- Hit: `score` += POINTS, saturating at all-ones. `streak` += 1, saturating.
- Miss: `streak` ← 0. `score` unchanged.

## Timing
- Reset: `hit`=0, `miss`=0, `score`=0, `streak`=0, `done`=0, state IDLE, `prev_keys`=0, `press_mask`=0, `expected`=0.
- `hit`, `miss`, `score`, `streak` and `done` are registered. Each changes in the cycle after the deciding state/condition.
- Beat pipeline: `new_beat` at cycle t → FETCH at t+1 (`song_data` for `cur_beat`(t) valid) → ACTIVE at t+2.
- A judgment needs ACTIVE. The earliest hit is visible at t+3.
- Key edges at t and t+1 count toward the new beat.
- Simultaneous events:
  - `new_beat` coincident with a completing press: the new_beat rule wins and a miss is emitted.
  - `new_beat` and `playing`=0 in the same cycle: go → IDLE, nothing emitted.
- `rst` mid-beat: all state returns to reset values next cycle. A pending hit/miss is dropped.
- `hit` and `miss` are never high in the same cycle.

## Test plan
- Reset, `playing`=1, chart beat 0 = 4'b0010, key1 rises at t+2 → `hit`=1 one cycle, `score`=10, `streak`=1.
- Chart 4'b0011: key0 rises, then key1 two cycles later → single hit once both are pressed, `score`+=10. Key2 pressed first instead → `miss`, `streak`=0, later presses ignored until next beat.
- Chart 4'b0100, no press, `new_beat` → `miss` one cycle after `new_beat`, `streak` 3→0, `score` unchanged. Rest beat (0) with presses → no hit/miss.
- Keys held across a beat boundary (no new edge) → miss on the next note beat; held level alone never scores.
- `score` preset near max via 6553 hits with `SCORE_BITS`=16 → saturates at 65535. Streak 255 + hit → stays 255.
- `playing`=0 mid-beat → IDLE, no miss; resume → FETCH. `cur_beat` reaches 64 → `done`=1 and held. `rst` mid-ACTIVE → all outputs 0 next cycle.
